hazard_detect_unit: RTL and testbench

//   Consumer of the decoder's rs1use/rs2use/hazard_optype outputs in the 5-stage RV32I pipeline.

---
 rtl/hazard_detect_unit.sv | 130 +++++++++++++
 tb/tb_hazard_detect_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect_unit.sv
// Hazard detection for the 5-stage RV32I pipeline: operand forwarding selects,
// load-use stall/bubble, branch flush and stall/flush event counters.
module hazard_detect_unit #(
  parameter int CNT_W     = 32,
  parameter bit LS_FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [1:0]       hazard_optype_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rd_ID,
  input  logic             Branch_ID,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic             PC_EN_IF,
  output logic             reg_FD_stall,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    OPT_NONE  = 2'b00,
    OPT_ALU   = 2'b01,
    OPT_LOAD  = 2'b10,
    OPT_STORE = 2'b11
  } optype_e;

  optype_e    ex_optype;
  optype_e    mem_optype;
  logic [4:0] ex_rd;
  logic [4:0] ex_rs2;
  logic [4:0] mem_rd;

  logic       ld_ex_rs1;
  logic       ld_ex_rs2;
  logic       store_fwd_ok;
  logic       load_use;
  logic       fd_flush;
  logic       ls_hit;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // EX ALU result has priority over anything older sitting in MEM.
  function automatic logic [1:0] fwd_sel(
    input logic       rs_used,
    input logic [4:0] rs,
    input optype_e    ex_op,
    input logic [4:0] ex_dst,
    input optype_e    mem_op,
    input logic [4:0] mem_dst
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs_used && (rs != 5'd0)) begin
      if ((ex_op == OPT_ALU) && (ex_dst == rs))
        sel = 2'b01;
      else if ((mem_op == OPT_ALU) && (mem_dst == rs))
        sel = 2'b10;
      else if ((mem_op == OPT_LOAD) && (mem_dst == rs))
        sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    ld_ex_rs1    = (rs1_ID != 5'd0) && (ex_optype == OPT_LOAD) && (ex_rd == rs1_ID);
    ld_ex_rs2    = (rs2_ID != 5'd0) && (ex_optype == OPT_LOAD) && (ex_rd == rs2_ID);
    // A store's data operand can be fed from MEM later, so only its address stalls.
    store_fwd_ok = LS_FWD_EN && (hazard_optype_ID == OPT_STORE);
    load_use     = (rs1use_ID && ld_ex_rs1) || (rs2use_ID && ld_ex_rs2 && !store_fwd_ok);
    fd_flush     = Branch_ID && !load_use;
    ls_hit       = LS_FWD_EN && (ex_optype == OPT_STORE) && (mem_optype == OPT_LOAD) &&
                   (ex_rs2 != 5'd0) && (mem_rd == ex_rs2);
    fwd_a        = fwd_sel(rs1use_ID, rs1_ID, ex_optype, ex_rd, mem_optype, mem_rd);
    fwd_b        = fwd_sel(rs2use_ID, rs2_ID, ex_optype, ex_rd, mem_optype, mem_rd);
  end

  // Outputs are forced to their idle values for the whole time reset is held.
  always_comb begin
    forward_ctrl_A  = 2'b00;
    forward_ctrl_B  = 2'b00;
    forward_ctrl_ls = 1'b0;
    PC_EN_IF        = 1'b1;
    reg_FD_stall    = 1'b0;
    reg_FD_flush    = 1'b0;
    reg_DE_flush    = 1'b0;
    if (rst_n) begin
      forward_ctrl_A  = fwd_a;
      forward_ctrl_B  = fwd_b;
      forward_ctrl_ls = ls_hit;
      PC_EN_IF        = !load_use;
      reg_FD_stall    = load_use;
      reg_FD_flush    = fd_flush;
      reg_DE_flush    = load_use;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_optype  <= OPT_NONE;
      ex_rd      <= 5'd0;
      ex_rs2     <= 5'd0;
      mem_optype <= OPT_NONE;
      mem_rd     <= 5'd0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      mem_optype <= ex_optype;
      mem_rd     <= ex_rd;
      if (load_use) begin
        ex_optype <= OPT_NONE;
        ex_rd     <= 5'd0;
        ex_rs2    <= 5'd0;
      end else begin
        ex_optype <= optype_e'(hazard_optype_ID);
        ex_rd     <= rd_ID;
        ex_rs2    <= rs2_ID;
      end
      stall_cnt <= stall_cnt + CNT_W'(load_use);
      flush_cnt <= flush_cnt + CNT_W'(fd_flush);
    end
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: directed vector table, hand sequences for
// store forwarding and mid-stall reset, then random stimulus against a model.
module tb_hazard_detect_unit;

  localparam int CW0 = 4;
  localparam logic [1:0] OP_NONE = 2'b00, OP_ALU = 2'b01, OP_LOAD = 2'b10, OP_STORE = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rs1use_ID, rs2use_ID, Branch_ID;
  logic [1:0] hazard_optype_ID;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;

  logic [1:0]  fa1, fb1, fa0, fb0;
  logic        ls1, pc1, fds1, fdf1, def1;
  logic        ls0, pc0, fds0, fdf0, def0;
  logic [31:0] sc1, fc1;
  logic [CW0-1:0] sc0, fc0;

  hazard_detect_unit #(.CNT_W(32), .LS_FWD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .hazard_optype_ID(hazard_optype_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .Branch_ID(Branch_ID), .forward_ctrl_A(fa1), .forward_ctrl_B(fb1), .forward_ctrl_ls(ls1),
    .PC_EN_IF(pc1), .reg_FD_stall(fds1), .reg_FD_flush(fdf1), .reg_DE_flush(def1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_detect_unit #(.CNT_W(CW0), .LS_FWD_EN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .hazard_optype_ID(hazard_optype_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .Branch_ID(Branch_ID), .forward_ctrl_A(fa0), .forward_ctrl_B(fb0), .forward_ctrl_ls(ls0),
    .PC_EN_IF(pc0), .reg_FD_stall(fds0), .reg_FD_flush(fdf0), .reg_DE_flush(def0),
    .stall_cnt(sc0), .flush_cnt(fc0));

  typedef struct packed {
    logic       u1, u2;
    logic [1:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] rd, rs2;
  } instr_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       ls, stall, flush;
  } exp_t;

  typedef struct {
    stim_t      s;
    logic [1:0] fa, fb;
    logic       ls, st, fl;
    int         sc, fc;
  } row_t;

  int n_tests = 0;
  int n_fail  = 0;

  stim_t       cur;
  // index 0 models u_dut (store forwarding on), index 1 models u_dut0 (off)
  instr_t      m_ex  [2];
  instr_t      m_mem [2];
  int unsigned m_sc  [2];
  int unsigned m_fc  [2];
  row_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Latest older producer of rs wins; a load still in EX cannot be forwarded yet.
  function automatic logic [1:0] src_sel(input instr_t ex, input instr_t mem,
                                         input logic used, input logic [4:0] rs);
    if (!used || rs == 5'd0) return 2'b00;
    if (ex.op == OP_ALU && ex.rd == rs) return 2'b01;
    if (mem.rd == rs && mem.op == OP_ALU) return 2'b10;
    if (mem.rd == rs && mem.op == OP_LOAD) return 2'b11;
    return 2'b00;
  endfunction

  function automatic exp_t predict(input int k);
    exp_t   e;
    instr_t ex, mem;
    logic   ls_en, dep1, dep2;
    ex    = m_ex[k];
    mem   = m_mem[k];
    ls_en = (k == 0);
    e.fa  = src_sel(ex, mem, cur.u1, cur.rs1);
    e.fb  = src_sel(ex, mem, cur.u2, cur.rs2);
    dep1  = cur.u1 && cur.rs1 != 5'd0 && ex.op == OP_LOAD && ex.rd == cur.rs1;
    dep2  = cur.u2 && cur.rs2 != 5'd0 && ex.op == OP_LOAD && ex.rd == cur.rs2 &&
            !(ls_en && cur.op == OP_STORE);
    e.stall = dep1 || dep2;
    e.flush = cur.br && !e.stall;
    e.ls    = ls_en && ex.op == OP_STORE && mem.op == OP_LOAD && ex.rs2 != 5'd0 &&
              mem.rd == ex.rs2;
    return e;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic set_in(input stim_t s);
    cur              = s;
    rs1use_ID        = s.u1;
    rs2use_ID        = s.u2;
    hazard_optype_ID = s.op;
    rs1_ID           = s.rs1;
    rs2_ID           = s.rs2;
    rd_ID            = s.rd;
    Branch_ID        = s.br;
  endtask

  task automatic cmp_dut(input string tag, input exp_t e,
                         input logic [1:0] fa, input logic [1:0] fb, input logic ls,
                         input logic pc, input logic fds, input logic fdf, input logic def,
                         input logic [31:0] sc, input logic [31:0] fc,
                         input logic [31:0] esc, input logic [31:0] efc);
    chk($sformatf("%s.fwd_A", tag), 32'(fa), 32'(e.fa));
    chk($sformatf("%s.fwd_B", tag), 32'(fb), 32'(e.fb));
    chk($sformatf("%s.fwd_ls", tag), 32'(ls), 32'(e.ls));
    chk($sformatf("%s.stall_ctl", tag), {29'd0, pc, fds, def}, {29'd0, !e.stall, e.stall, e.stall});
    chk($sformatf("%s.fd_flush", tag), 32'(fdf), 32'(e.flush));
    chk($sformatf("%s.stall_cnt", tag), sc, esc);
    chk($sformatf("%s.flush_cnt", tag), fc, efc);
  endtask

  task automatic check_cycle();
    @(negedge clk);
    cmp_dut("m1", predict(0), fa1, fb1, ls1, pc1, fds1, fdf1, def1, sc1, fc1, m_sc[0], m_fc[0]);
    cmp_dut("m0", predict(1), fa0, fb0, ls0, pc0, fds0, fdf0, def0, 32'(sc0), 32'(fc0),
            m_sc[1] & 32'hF, m_fc[1] & 32'hF);
  endtask

  task automatic advance();
    exp_t e;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      e = predict(k);
      m_sc[k] += 32'(e.stall);
      m_fc[k] += 32'(e.flush);
      m_mem[k] = m_ex[k];
      m_ex[k]  = e.stall ? instr_t'('0) : instr_t'({cur.op, cur.rd, cur.rs2});
    end
    #1;
  endtask

  task automatic step(input stim_t s);
    set_in(s);
    check_cycle();
    advance();
  endtask

  task automatic check_idle(input string tag);
    chk($sformatf("%s.fwd", tag), {26'd0, fa1, fb1, ls1, fa0, fb0, ls0}, 32'd0);
    chk($sformatf("%s.pc_en", tag), {30'd0, pc1, pc0}, 32'd3);
    chk($sformatf("%s.ctl", tag), {26'd0, fds1, fdf1, def1, fds0, fdf0, def0}, 32'd0);
    chk($sformatf("%s.cnt1", tag), sc1 | fc1, 32'd0);
    chk($sformatf("%s.cnt0", tag), 32'(sc0 | fc0), 32'd0);
  endtask

  // Reset is held while a branch is presented to prove the outputs are gated.
  task automatic do_reset();
    rst_n = 1'b0;
    set_in('{u1:1'b1, u2:1'b1, op:OP_ALU, rs1:5'd1, rs2:5'd2, rd:5'd3, br:1'b1});
    #2;
    check_idle("reset");
    set_in('0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk(input logic u1, input logic u2, input logic [1:0] op,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic br, input logic [1:0] fa, input logic [1:0] fb,
                              input logic ls, input logic st, input logic fl,
                              input int sc, input int fc);
    row_t r;
    r.s  = '{u1:u1, u2:u2, op:op, rs1:rs1, rs2:rs2, rd:rd, br:br};
    r.fa = fa; r.fb = fb; r.ls = ls; r.st = st; r.fl = fl; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b1;
    set_in('0);
    model_clear();

    //          u1 u2 op rs1 rs2 rd br | fa fb ls st fl sc fc
    tbl.push_back(mk(1, 1, 1, 2, 3, 1, 0,  0, 0, 0, 0, 0, 0, 0)); // add x1,x2,x3
    tbl.push_back(mk(1, 1, 1, 1, 3, 2, 0,  1, 0, 0, 0, 0, 0, 0)); // add x2,x1,x3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // nop
    tbl.push_back(mk(1, 1, 1, 5, 2, 4, 0,  0, 2, 0, 0, 0, 0, 0)); // sub x4,x5,x2
    tbl.push_back(mk(1, 0, 2, 6, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0)); // lw x1,0(x6)
    tbl.push_back(mk(1, 1, 1, 1, 2, 3, 0,  0, 0, 0, 1, 0, 0, 0)); // add x3,x1,x2 stalls
    tbl.push_back(mk(1, 1, 1, 1, 2, 3, 0,  3, 0, 0, 0, 0, 1, 0)); // held, load data fwd
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0)); // addi x0
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, 0,  0, 0, 0, 0, 0, 1, 0)); // add x2,x0,x0
    tbl.push_back(mk(1, 0, 2, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0)); // lw x0,0(x1)
    tbl.push_back(mk(1, 1, 1, 0, 0, 5, 0,  0, 0, 0, 0, 0, 1, 0)); // add x5,x0,x0
    tbl.push_back(mk(1, 1, 0, 7, 8, 0, 1,  0, 0, 0, 0, 1, 1, 0)); // taken beq x7,x8
    tbl.push_back(mk(1, 0, 2, 7, 0, 9, 0,  0, 0, 0, 0, 0, 1, 1)); // lw x9,0(x7)
    tbl.push_back(mk(1, 1, 0, 9, 0, 0, 1,  0, 0, 0, 1, 0, 1, 1)); // beq x9: stall beats flush
    tbl.push_back(mk(1, 1, 0, 9, 0, 0, 1,  3, 0, 0, 0, 1, 2, 1)); // beq re-evaluated
    tbl.push_back(mk(1, 0, 2, 1, 0, 5, 0,  0, 0, 0, 0, 0, 2, 2)); // lw x5,0(x1)
    tbl.push_back(mk(1, 1, 3, 6, 5, 0, 0,  0, 0, 0, 0, 0, 2, 2)); // sw x5,0(x6)
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 2, 2)); // store takes load data
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 2)); // nop

    #2;
    do_reset();
    foreach (tbl[i]) begin
      set_in(tbl[i].s);
      check_cycle();
      cmp_dut($sformatf("row%0d", i), '{fa:tbl[i].fa, fb:tbl[i].fb, ls:tbl[i].ls,
              stall:tbl[i].st, flush:tbl[i].fl},
              fa1, fb1, ls1, pc1, fds1, fdf1, def1, sc1, fc1, 32'(tbl[i].sc), 32'(tbl[i].fc));
      advance();
    end

    // Store whose address depends on a load in EX must still stall.
    do_reset();
    step('{u1:1, u2:0, op:OP_LOAD, rs1:5'd1, rs2:5'd0, rd:5'd6, br:0});
    set_in('{u1:1, u2:1, op:OP_STORE, rs1:5'd6, rs2:5'd5, rd:5'd0, br:0});
    check_cycle();
    chk("st_addr.stall", 32'(fds1), 32'd1);
    advance();
    check_cycle();
    chk("st_addr.fwdA", 32'(fa1), 32'd3);
    advance();

    // Load then dependent store data: forward with LS_FWD_EN=1, stall without.
    step('{u1:1, u2:0, op:OP_LOAD, rs1:5'd1, rs2:5'd0, rd:5'd5, br:0});
    set_in('{u1:1, u2:1, op:OP_STORE, rs1:5'd6, rs2:5'd5, rd:5'd0, br:0});
    check_cycle();
    chk("ls.on.stall", 32'(fds1), 32'd0);
    chk("ls.off.stall", 32'(fds0), 32'd1);
    advance();
    check_cycle();
    chk("ls.on.fwd_ls", 32'(ls1), 32'd1);
    chk("ls.off.fwd_ls", 32'(ls0), 32'd0);
    advance();

    // Reset asserted while a stall and a branch are both being presented.
    do_reset();
    step('{u1:1, u2:0, op:OP_LOAD, rs1:5'd2, rs2:5'd0, rd:5'd1, br:0});
    set_in('{u1:1, u2:1, op:OP_ALU, rs1:5'd1, rs2:5'd1, rd:5'd3, br:1});
    check_cycle();
    chk("midstall.pre", 32'(pc1), 32'd0);
    #1 rst_n = 1'b0;
    #1 check_idle("midstall.rst");
    set_in('0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    step('0);

    // Random traffic on a small register set so hazards are frequent.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.op  = 2'($urandom_range(0, 3));
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.br  = ($urandom_range(0, 3) == 0);
      step(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
